// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: PC-source codes, register zero, FSM states.
package hazard_ctrl_pkg;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JR     = 3'b011;
  localparam logic [4:0] REG_ZERO     = 5'd0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    EXC   = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_match.sv
// Register-field comparators for load-use, ALU->branch, load->branch and mem-load->branch hazards.
// Purely combinational, zero latency, no flow control.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  input  logic       i_ifid_usert,
  input  logic [2:0] i_ifid_pcsrc,
  input  logic       i_idex_memrd,
  input  logic       i_idex_regwr,
  input  logic [4:0] i_idex_wdst,
  input  logic       i_exmem_memrd,
  input  logic [4:0] i_exmem_rt,
  output logic       o_lu,
  output logic       o_ab,
  output logic       o_lb,
  output logic       o_mb
);
  logic w_is_br, w_cmp, w_ex_rs, w_ex_rt, w_ex_op, w_mem_op;

  assign w_is_br = (i_ifid_pcsrc == PCSRC_BRANCH);
  assign w_cmp   = w_is_br | (i_ifid_pcsrc == PCSRC_JR);

  // jr compares only rs; a branch compares both operands
  assign w_ex_rs  = (i_idex_wdst != REG_ZERO) & (i_idex_wdst == i_ifid_rs);
  assign w_ex_rt  = (i_idex_wdst != REG_ZERO) & (i_idex_wdst == i_ifid_rt);
  assign w_ex_op  = w_ex_rs | (w_is_br & w_ex_rt);
  assign w_mem_op = (i_exmem_rt != REG_ZERO) &
                    ((i_exmem_rt == i_ifid_rs) | (w_is_br & (i_exmem_rt == i_ifid_rt)));

  assign o_lu = i_idex_memrd & (w_ex_rs | (i_ifid_usert & w_ex_rt));
  assign o_ab = w_cmp & i_idex_regwr & ~i_idex_memrd & w_ex_op;
  assign o_lb = w_cmp & i_idex_memrd & w_ex_op;
  assign o_mb = w_cmp & i_exmem_memrd & w_mem_op;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core; outputs combinational from state and inputs.
// Optional saturating stall/flush counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int PERF_W     = 16,
  parameter int LDBR_STALL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        IFID_rs,
  input  logic [4:0]        IFID_rt,
  input  logic              IFID_usert,
  input  logic [2:0]        IFID_pcsrc,
  input  logic              IDEX_memrd,
  input  logic              IDEX_regwr,
  input  logic [4:0]        IDEX_wdst,
  input  logic              EXMEM_memrd,
  input  logic [4:0]        EXMEM_rt,
  input  logic              br_taken,
  input  logic              exc_req,
  output logic              pc_wr,
  output logic              ifid_wr,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_flush,
  output logic              pc_exc_sel,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);
  localparam logic [1:0] LDBR_INIT = 2'(LDBR_STALL - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;
  logic       w_lu, w_ab, w_lb, w_mb;
  logic       w_pc_wr, w_ifid_wr, w_ifid_flush, w_idex_bubble, w_exmem_flush, w_pc_exc_sel;

  hazard_match u_match (
    .i_ifid_rs    (IFID_rs),
    .i_ifid_rt    (IFID_rt),
    .i_ifid_usert (IFID_usert),
    .i_ifid_pcsrc (IFID_pcsrc),
    .i_idex_memrd (IDEX_memrd),
    .i_idex_regwr (IDEX_regwr),
    .i_idex_wdst  (IDEX_wdst),
    .i_exmem_memrd(EXMEM_memrd),
    .i_exmem_rt   (EXMEM_rt),
    .o_lu         (w_lu),
    .o_ab         (w_ab),
    .o_lb         (w_lb),
    .o_mb         (w_mb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pc_wr       = 1'b1;
    w_ifid_wr     = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_flush = 1'b0;
    w_pc_exc_sel  = 1'b0;
    if ((r_state != EXC) && exc_req) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_exmem_flush = 1'b1;
      w_pc_exc_sel  = 1'b1;
      w_cnt_nxt     = 2'd0;
      w_state_nxt   = EXC;
    end else begin
      case (r_state)
        RUN: begin
          // load->branch first: it also matches lu and needs the longer stall
          if (w_lb) begin
            w_pc_wr       = 1'b0;
            w_ifid_wr     = 1'b0;
            w_idex_bubble = 1'b1;
            w_cnt_nxt     = LDBR_INIT;
            w_state_nxt   = (LDBR_INIT != 2'd0) ? STALL : RUN;
          end else if (w_lu || w_ab || w_mb) begin
            w_pc_wr       = 1'b0;
            w_ifid_wr     = 1'b0;
            w_idex_bubble = 1'b1;
          end else if (br_taken) begin
            w_ifid_flush  = 1'b1;
          end
        end
        STALL: begin
          w_pc_wr       = 1'b0;
          w_ifid_wr     = 1'b0;
          w_idex_bubble = 1'b1;
          if (r_cnt != 2'd0) w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) w_state_nxt = RUN;
        end
        EXC: begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
          w_state_nxt   = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // Hold idle values while reset is asserted, whatever the hazard inputs show
  assign pc_wr       = reset ? w_pc_wr       : 1'b1;
  assign ifid_wr     = reset ? w_ifid_wr     : 1'b1;
  assign ifid_flush  = reset & w_ifid_flush;
  assign idex_bubble = reset & w_idex_bubble;
  assign exmem_flush = reset & w_exmem_flush;
  assign pc_exc_sel  = reset & w_pc_exc_sel;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_wr && (r_stall_cnt != '1))     r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (ifid_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector table plus hand sequences for load->branch stall, exception and async reset.
module tb_hazard_ctrl;
  localparam int PERF_W = 16;
  // {pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_flush, pc_exc_sel}
  localparam logic [5:0] IDLE   = 6'b110000;
  localparam logic [5:0] STL    = 6'b000100;
  localparam logic [5:0] FLSH   = 6'b111000;
  localparam logic [5:0] EXCREQ = 6'b111111;
  localparam logic [5:0] EXCST  = 6'b111100;

  logic              clk = 1'b0;
  logic              reset;
  logic [4:0]        IFID_rs, IFID_rt, IDEX_wdst, EXMEM_rt;
  logic              IFID_usert, IDEX_memrd, IDEX_regwr, EXMEM_memrd, br_taken, exc_req;
  logic [2:0]        IFID_pcsrc;
  logic              pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_flush, pc_exc_sel;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usert;
    logic [2:0] pcsrc;
    logic       idmem;
    logic       idreg;
    logic [4:0] wdst;
    logic       exmem;
    logic [4:0] exrt;
    logic       brt;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[14];

  hazard_ctrl #(.PERF_W(PERF_W), .LDBR_STALL(2)) dut (
    .clk(clk), .reset(reset),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_usert(IFID_usert), .IFID_pcsrc(IFID_pcsrc),
    .IDEX_memrd(IDEX_memrd), .IDEX_regwr(IDEX_regwr), .IDEX_wdst(IDEX_wdst),
    .EXMEM_memrd(EXMEM_memrd), .EXMEM_rt(EXMEM_rt),
    .br_taken(br_taken), .exc_req(exc_req),
    .pc_wr(pc_wr), .ifid_wr(ifid_wr), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .exmem_flush(exmem_flush), .pc_exc_sel(pc_exc_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic apply(input vec_t v);
    IFID_rs = v.rs; IFID_rt = v.rt; IFID_usert = v.usert; IFID_pcsrc = v.pcsrc;
    IDEX_memrd = v.idmem; IDEX_regwr = v.idreg; IDEX_wdst = v.wdst;
    EXMEM_memrd = v.exmem; EXMEM_rt = v.exrt; br_taken = v.brt;
  endtask

  task automatic set_idle();
    IFID_rs = 5'd0; IFID_rt = 5'd0; IFID_usert = 1'b0; IFID_pcsrc = 3'b000;
    IDEX_memrd = 1'b0; IDEX_regwr = 1'b0; IDEX_wdst = 5'd0;
    EXMEM_memrd = 1'b0; EXMEM_rt = 5'd0; br_taken = 1'b0; exc_req = 1'b0;
  endtask

  task automatic set_ldbr(input logic brt);
    set_idle();
    IFID_rt = 5'd9; IFID_usert = 1'b1; IFID_pcsrc = 3'b001;
    IDEX_memrd = 1'b1; IDEX_regwr = 1'b1; IDEX_wdst = 5'd9; br_taken = brt;
  endtask

  task automatic cmp6(input string nm, input logic [5:0] e);
    logic [5:0] a;
    a = {pc_wr, ifid_wr, ifid_flush, idex_bubble, exmem_flush, pc_exc_sel};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: outputs got %b want %b", nm, a, e);
    end
  endtask

  task automatic cmpv(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // Check outputs mid-cycle, then advance to just after the next rising edge
  task automatic chk(input string nm, input logic [5:0] e);
    @(negedge clk);
    cmp6(nm, e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string nm, input logic [1:0] e);
    cmpv(nm, {30'b0, dut.r_state}, {30'b0, e});
  endtask

  initial begin
    logic [31:0] exp_st, exp_fl;
`ifdef HAZARD_PERF_CNT_EN
    exp_st = 32'd3; exp_fl = 32'd1;
`else
    exp_st = 32'd0; exp_fl = 32'd0;
`endif
    //         rs     rt     us    pcsrc   idm   idr   wdst   exm   exrt   brt   exp
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, IDLE};
    vecs[1]  = '{5'd8, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, STL};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, IDLE};
    vecs[3]  = '{5'd1, 5'd5, 1'b0, 3'b000, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, IDLE};
    vecs[4]  = '{5'd1, 5'd5, 1'b1, 3'b000, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, STL};
    vecs[5]  = '{5'd2, 5'd3, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, FLSH};
    vecs[6]  = '{5'd1, 5'd7, 1'b1, 3'b001, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, STL};
    vecs[7]  = '{5'd3, 5'd7, 1'b0, 3'b011, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, FLSH};
    vecs[8]  = '{5'd4, 5'd0, 1'b1, 3'b001, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b1, STL};
    vecs[9]  = '{5'd0, 5'd0, 1'b1, 3'b001, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, IDLE};
    vecs[10] = '{5'd0, 5'd2, 1'b1, 3'b001, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, IDLE};
    vecs[11] = '{5'd6, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, STL};
    vecs[12] = '{5'd3, 5'd0, 1'b0, 3'b010, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, FLSH};
    vecs[13] = '{5'd2, 5'd4, 1'b0, 3'b011, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0, IDLE};

    reset = 1'b0;
    set_idle();
    #2;
    cmp6("reset_out", IDLE);
    chk_state("reset_state", 2'd0);
    cmpv("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    cmpv("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    #5 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Load-use stalls exactly one cycle
    set_idle(); IDEX_memrd = 1'b1; IDEX_wdst = 5'd8; IFID_rs = 5'd8;
    chk("lu_c1", STL);
    set_idle();
    chk("lu_c2", IDLE);

    // Load->beq: two stall cycles, taken branch ignored while stalled
    set_ldbr(1'b1);
    chk_state("ldbr_st1", 2'd0);
    chk("ldbr_c1", STL);
    chk_state("ldbr_st2", 2'd1);
    chk("ldbr_c2", STL);
    set_idle(); br_taken = 1'b1; IFID_pcsrc = 3'b001;
    chk_state("ldbr_st3", 2'd0);
    chk("ldbr_c3", FLSH);
    set_idle();
    chk("ldbr_c4", IDLE);

    // Exception in second stall cycle, held high through EXC, re-triggers in RUN
    set_ldbr(1'b0);
    chk("exc_c1", STL);
    exc_req = 1'b1;
    chk_state("exc_st2", 2'd1);
    chk("exc_c2", EXCREQ);
    chk_state("exc_st3", 2'd2);
    chk("exc_c3", EXCST);
    chk_state("exc_st4", 2'd0);
    chk("exc_c4", EXCREQ);
    set_idle();
    chk("exc_c5", EXCST);
    chk("exc_c6", IDLE);

    // Async reset in the middle of STALL, then counter accumulation
    set_ldbr(1'b0);
    chk("rst_c1", STL);
    #2 reset = 1'b0;
    #1;
    cmp6("rst_async_out", IDLE);
    chk_state("rst_async_state", 2'd0);
    cmpv("rst_async_stall_cnt", 32'(stall_cnt), 32'd0);
    cmpv("rst_async_flush_cnt", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    chk("perf_c1", STL);
    chk("perf_c2", STL);
    set_idle(); IDEX_memrd = 1'b1; IDEX_wdst = 5'd8; IFID_rs = 5'd8;
    chk("perf_c3", STL);
    set_idle(); IFID_pcsrc = 3'b011; br_taken = 1'b1;
    chk("perf_c4", FLSH);
    set_idle();
    cmpv("perf_stall_cnt", 32'(stall_cnt), exp_st);
    cmpv("perf_flush_cnt", 32'(flush_cnt), exp_fl);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Consumes ID-stage (IF/ID) and EX-stage (ID/EX, EX/MEM) register fields and resolves the hazards the forwarding unit cannot cover: load-use, branch/jr operand not ready in ID, and exception flush.
- Drives PC write-enable, IF/ID write/flush, ID/EX bubble and EX/MEM flush.
- Sits beside the forwarding unit in the top-level CPU.

Parameters:
- PERF_W, 16, width of the optional stall/flush performance counters.
- LDBR_STALL, 2, stall cycles for a branch/jr whose operand comes from a load currently in ID/EX (legal range 1..3).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-low reset
- IFID_rs  in  5  rs field of the instruction in ID
- IFID_rt  in  5  rt field of the instruction in ID
- IFID_usert  in  1  instruction in ID reads rt (R-type, beq/bne, sw)
- IFID_pcsrc  in  3  PC source of the ID instruction: 001 = branch, 011 = jr, others = no ID-stage compare
- IDEX_memrd  in  1  instruction in EX is a load
- IDEX_regwr  in  1  instruction in EX writes a register
- IDEX_wdst  in  5  destination register of the EX instruction
- EXMEM_memrd  in  1  instruction in MEM is a load
- EXMEM_rt  in  5  load destination of the MEM instruction
- br_taken  in  1  branch/jump resolved taken in ID this cycle
- exc_req  in  1  exception/interrupt request from MEM stage, level
- pc_wr  out  1  PC register write enable
- ifid_wr  out  1  IF/ID write enable
- ifid_flush  out  1  IF/ID cleared to nop
- idex_bubble  out  1  ID/EX loaded with nop (control bits zero)
- exmem_flush  out  1  EX/MEM control bits zeroed
- pc_exc_sel  out  1  PC mux selects the exception vector
- stall_cnt  out  PERF_W  stalled-cycle counter (feature only)
- flush_cnt  out  PERF_W  flush-event counter (feature only)

Behaviour:
- FSM states: RUN, STALL, EXC.
  - State register and down counter cnt (2 bits) reset asynchronously to RUN, cnt = 0.
- Outputs are combinational from state and inputs.
  - Reset/idle values: pc_wr = 1, ifid_wr = 1, all other outputs 0.
- Hazard terms (destination register 0 never matches):
  - lu = IDEX_memrd & IDEX_wdst != 0 & (IDEX_wdst == IFID_rs | (IFID_usert & IDEX_wdst == IFID_rt))
  - cmp = IFID_pcsrc is 001 or 011
  - ab = cmp & IDEX_regwr & ~IDEX_memrd & IDEX_wdst matches IFID_rs or IFID_rt (rt only for 001)
  - lb = cmp & lu-style match
  - mb = cmp & EXMEM_memrd & EXMEM_rt != 0 & EXMEM_rt matches an operand
- RUN:
  - If lu, ab or mb: assert stall for this cycle (pc_wr = 0, ifid_wr = 0, idex_bubble = 1) and stay in RUN. Re-evaluation next cycle covers the advanced pipeline.
  - If lb: assert stall, load cnt = LDBR_STALL-1. Go to STALL if cnt > 0, else stay in RUN.
  - Else if br_taken: ifid_flush = 1 for one cycle.
  - Stall beats flush: br_taken is ignored in any stalled cycle.
- STALL:
  - Stall asserted unconditionally; cnt decrements.
  - Return to RUN in the cycle cnt reaches 0 (that cycle still stalls).
  - br_taken ignored.
- exc_req in RUN or STALL: enter EXC next cycle; exc_req overrides all hazards.
  - In the request cycle: ifid_flush = 1, idex_bubble = 1, exmem_flush = 1, pc_exc_sel = 1, pc_wr = 1.
  - cnt clears.
- EXC: single cycle with ifid_flush = 1, idex_bubble = 1, pc_wr = 1, pc_exc_sel = 0; then RUN.
  - exc_req is ignored while in EXC.
  - exc_req held high re-triggers only after returning to RUN.
- Reset asserted mid-stall or mid-EXC: immediately RUN, outputs at idle values; no pending stall survives.
- Total stall cycles for a load→branch pair = LDBR_STALL exactly.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- With it defined:
  - stall_cnt increments on every cycle with pc_wr = 0.
  - flush_cnt increments on every cycle with ifid_flush = 1.
  - Both counters saturate at all-ones and reset to 0.
- Without it: both counters are tied to 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - PCSRC_BRANCH = 3'b001, PCSRC_JR = 3'b011
  - FSM state encoding typedef (RUN = 0, STALL = 1, EXC = 2)
  - REG_ZERO = 5'd0
- One sub-module, hazard_match: pure combinational computation of lu/ab/lb/mb from register fields.
- FSM and counters stay in hazard_ctrl.

Test Plan:
- Load-use: IDEX_memrd = 1, IDEX_wdst = 8, IFID_rs = 8 -> exactly 1 cycle of pc_wr = 0, ifid_wr = 0, idex_bubble = 1; next cycle idle (pc_wr = 1).
- Load→beq: IDEX_memrd = 1, IDEX_wdst = 9, IFID_pcsrc = 001, IFID_rt = 9, LDBR_STALL = 2 -> stall 2 consecutive cycles, state STALL in cycle 2, RUN after; br_taken = 1 during stall produces no ifid_flush.
- Register 0 / non-use: IDEX_memrd = 1, IDEX_wdst = 0, IFID_rs = 0 -> no stall; IDEX_wdst = 5, IFID_rt = 5, IFID_usert = 0 -> no stall.
- Taken jr with no hazard: IFID_pcsrc = 011, br_taken = 1 -> ifid_flush = 1 for 1 cycle, pc_wr stays 1.
- Exception during STALL: exc_req = 1 in second load→branch stall cycle -> that cycle pc_exc_sel = 1, all three flushes = 1, pc_wr = 1; next cycle EXC (pc_exc_sel = 0); then RUN.
- Async reset mid-STALL, plus HAZARD_PERF_CNT_EN build: reset = 0 between clock edges -> outputs idle immediately, counters 0; after 3 stalled cycles and 1 flush, stall_cnt = 3, flush_cnt = 1.
